lion_gate_driver: RTL and testbench
===================================

LION_GATE_DRIVER -- requirements
Module: lion_gate_driver

Interface
REQ-001 Parameter: LEN_W, default 4, width of the phase-length input and its internal timer.
REQ-002 Port: clk  input  1  system clock; all state changes on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: cmd_valid  input  1  traversal request present.
REQ-005 Port: cmd_dir  input  1  direction: 0 = enter (gate one first), 1 = exit (gate two first).
REQ-006 Port: cmd_len  input  LEN_W  phase length; each phase lasts cmd_len+1 cycles.
REQ-007 Port: cmd_ready  output  1  block idle and able to accept a request.
REQ-008 Port: gate_one  output  1  emulated outer light barrier, 1 = beam broken.
REQ-009 Port: gate_two  output  1  emulated inner light barrier, 1 = beam broken.
REQ-010 Port: busy  output  1  traversal in progress.
REQ-011 Port: done  output  1  one-cycle pulse at end of a traversal.
REQ-012 Port: model_count  output  4  expected lion count as seen by a two-gate counter.

Function
REQ-013 Request accepted on a rising edge where cmd_valid=1 and cmd_ready=1; cmd_dir and cmd_len latched on that edge.
REQ-014 cmd_ready shall be 1 only in IDLE; it is combinational on state, so requests while busy are stalled, not dropped.
REQ-015 FSM states: IDLE, P1, P2, P3, GAP; IDLE->P1 on accept; P1->P2->P3->GAP->IDLE on timer expiry.
REQ-016 Each of P1, P2, P3, GAP shall last exactly latched_len+1 cycles; the timer loads on state entry and counts down to 0.
REQ-017 gate_one/gate_two shall be registered outputs, valid the cycle the state is entered.
REQ-018 Enter pattern (g1,g2): P1=(1,0), P2=(1,1), P3=(0,1), GAP=(0,0).
REQ-019 Exit pattern (g1,g2): P1=(0,1), P2=(1,1), P3=(1,0), GAP=(0,0).
REQ-020 IDLE pattern shall be (0,0); at most one gate output shall change per clock edge.
REQ-021 busy shall be 1 in P1, P2, P3 and GAP; 0 in IDLE.
REQ-022 done shall pulse high for exactly one cycle, on the first IDLE cycle after GAP; cmd_ready is also 1 in that cycle.
REQ-023 Enter: model_count shall increment on the edge entering P1, the edge where gate_one rises while gate_two=0.
REQ-024 Exit: model_count shall decrement on the edge from P3 to GAP, the edge where gate_one falls while gate_two=0.
REQ-025 model_count arithmetic is modulo 16: 15+1 -> 0 and 0-1 -> 15; no saturation.
REQ-026 A request accepted in the done cycle shall start P1 on the next edge, with no extra idle cycle.
REQ-027 Command-accept to done latency shall be 4*(cmd_len+1)+1 cycles.

Reset
REQ-028 While reset=1: state IDLE, timer 0, gate_one=0, gate_two=0, busy=0, done=0, model_count=0; cmd_ready=1 from the first cycle after reset.
REQ-029 Reset asserted mid-traversal shall abort it on that edge with no done pulse; model_count returns to 0 regardless of any partial update.
REQ-030 reset has priority over cmd_valid in the same cycle.

Verification
REQ-031 Enter with cmd_len=0 accepted at edge k -> (g1,g2) = (1,0),(1,1),(0,1),(0,0) at k+1..k+4; done and cmd_ready at k+5; model_count 0->1 at k+1.
REQ-032 Exit with cmd_len=2 from model_count=1 -> each phase held 3 cycles; model_count 1->0 on entry to GAP; done 13 cycles after accept.
REQ-033 Exit from model_count=0 -> model_count=15. Then 1 enter -> model_count=0 (wrap both ways).
REQ-034 cmd_valid held high through a traversal -> second command accepted in the done cycle; its P1 follows immediately, and no command is lost or duplicated.
REQ-035 reset during P2 of an enter -> next cycle: gates (0,0), busy=0, done never pulses, model_count=0, cmd_ready=1.
REQ-036 Bench checker: run 50 random enter/exit commands with random cmd_len; a reference two-gate counter fed gate_one/gate_two shall equal model_count at every done pulse.

Source files
------------

// File: rtl/lion_gate_driver.sv
// Emulates a lion passing through a two-beam gate (enter or exit) and tracks
// the lion count a two-gate counter would derive from the beam sequence.
module lion_gate_driver #(
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic             cmd_dir,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             cmd_ready,
  output logic             gate_one,
  output logic             gate_two,
  output logic             busy,
  output logic             done,
  output logic [3:0]       model_count
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_P1   = 3'd1,
    S_P2   = 3'd2,
    S_P3   = 3'd3,
    S_GAP  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] timer_q, timer_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             dir_q, dir_d;
  logic [1:0]       gates_q, gates_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [3:0]       count_q, count_d;
  logic             accept_s;
  logic             expire_s;

  // Beam pattern {gate_one, gate_two} for a state; dir=1 mirrors the outer phases.
  function automatic logic [1:0] gate_pattern(input state_t st, input logic dir);
    logic [1:0] pat;
    case (st)
      S_P1:    pat = dir ? 2'b01 : 2'b10;
      S_P2:    pat = 2'b11;
      S_P3:    pat = dir ? 2'b10 : 2'b01;
      S_GAP:   pat = 2'b00;
      default: pat = 2'b00;
    endcase
    return pat;
  endfunction

  assign cmd_ready = (state_q == S_IDLE);
  assign accept_s  = cmd_valid & cmd_ready;
  assign expire_s  = (timer_q == {LEN_W{1'b0}});

  // Next-state, phase timer and count update.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    len_d   = len_q;
    dir_d   = dir_q;
    count_d = count_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          state_d = S_P1;
          timer_d = cmd_len;
          len_d   = cmd_len;
          dir_d   = cmd_dir;
          // Entering lion: gate_one rises with gate_two clear on this edge.
          if (!cmd_dir) begin
            count_d = count_q + 4'd1;
          end else begin
            count_d = count_q;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_P1: begin
        if (expire_s) begin
          state_d = S_P2;
          timer_d = len_q;
        end else begin
          timer_d = timer_q - {{(LEN_W-1){1'b0}}, 1'b1};
        end
      end
      S_P2: begin
        if (expire_s) begin
          state_d = S_P3;
          timer_d = len_q;
        end else begin
          timer_d = timer_q - {{(LEN_W-1){1'b0}}, 1'b1};
        end
      end
      S_P3: begin
        if (expire_s) begin
          state_d = S_GAP;
          timer_d = len_q;
          // Exiting lion: gate_one falls with gate_two clear on this edge.
          if (dir_q) begin
            count_d = count_q - 4'd1;
          end else begin
            count_d = count_q;
          end
        end else begin
          timer_d = timer_q - {{(LEN_W-1){1'b0}}, 1'b1};
        end
      end
      S_GAP: begin
        if (expire_s) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          timer_d = timer_q - {{(LEN_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = S_IDLE;
        timer_d = {LEN_W{1'b0}};
      end
    endcase

    gates_d = gate_pattern(state_d, dir_d);
    busy_d  = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      timer_q <= {LEN_W{1'b0}};
      len_q   <= {LEN_W{1'b0}};
      dir_q   <= 1'b0;
      gates_q <= 2'b00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      count_q <= 4'd0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      len_q   <= len_d;
      dir_q   <= dir_d;
      gates_q <= gates_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      count_q <= count_d;
    end
  end

  assign gate_one    = gates_q[1];
  assign gate_two    = gates_q[0];
  assign busy        = busy_q;
  assign done        = done_q;
  assign model_count = count_q;

endmodule

// File: tb/tb_lion_gate_driver.sv
// Self-checking bench for lion_gate_driver: directed phase checks plus a
// scoreboard of expected count/latency popped at each done pulse.
module tb_lion_gate_driver;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_dir;
  logic [3:0] cmd_len;
  logic       cmd_ready;
  logic       gate_one;
  logic       gate_two;
  logic       busy;
  logic       done;
  logic [3:0] model_count;

  lion_gate_driver #(.LEN_W(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_dir     (cmd_dir),
    .cmd_len     (cmd_len),
    .cmd_ready   (cmd_ready),
    .gate_one    (gate_one),
    .gate_two    (gate_two),
    .busy        (busy),
    .done        (done),
    .model_count (model_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         acc_cyc;
    int         lat;
    logic [3:0] cnt;
  } exp_t;

  exp_t       sb_q[$];
  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  int         n_acc    = 0;
  int         n_done   = 0;
  logic [3:0] exp_cnt  = 4'd0;
  logic [3:0] ref_cnt  = 4'd0;
  logic [1:0] prev_g   = 2'b00;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Monitor: reference two-gate counter, scoreboard push on accept, pop on done.
  always @(negedge clk) begin
    logic [1:0] g;
    exp_t       e;
    cyc++;
    if (reset) begin
      exp_cnt = 4'd0;
      ref_cnt = 4'd0;
      prev_g  = 2'b00;
      sb_q.delete();
    end else begin
      g = {gate_one, gate_two};
      check_eq("one_gate_change", ($countones(g ^ prev_g) <= 1) ? 32'd1 : 32'd0, 32'd1);
      if (g[1] && !prev_g[1] && !g[0]) ref_cnt = ref_cnt + 4'd1;
      if (!g[1] && prev_g[1] && !g[0]) ref_cnt = ref_cnt - 4'd1;
      prev_g = g;
      if (done) begin
        n_done++;
        if (sb_q.size() == 0) begin
          check_eq("done_unexpected", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check_eq("latency", cyc - e.acc_cyc, e.lat);
          check_eq("sb_count", model_count, e.cnt);
          check_eq("ref_count", model_count, ref_cnt);
        end
      end
      if (cmd_valid && cmd_ready) begin
        n_acc++;
        exp_cnt = cmd_dir ? exp_cnt - 4'd1 : exp_cnt + 4'd1;
        e.acc_cyc = cyc;
        e.lat     = 4 * (int'(cmd_len) + 1) + 1;
        e.cnt     = exp_cnt;
        sb_q.push_back(e);
      end
    end
  end

  task automatic do_cmd(input logic dir, input logic [3:0] len);
    int n = 0;
    @(posedge clk); #1;
    while (!cmd_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("ready_timeout", (n < 200) ? 32'd1 : 32'd0, 32'd1);
    cmd_valid = 1'b1;
    cmd_dir   = dir;
    cmd_len   = len;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    @(negedge clk);
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, (n < 300) ? 32'd1 : 32'd0, 32'd1);
  endtask

  // Samples every phase cycle after an accept; ends in the done cycle.
  task automatic check_phases(input logic dir, input logic [3:0] len, input logic [3:0] start);
    logic [1:0] pat [4];
    logic [3:0] c;
    if (dir) begin
      pat[0] = 2'b01; pat[1] = 2'b11; pat[2] = 2'b10; pat[3] = 2'b00;
    end else begin
      pat[0] = 2'b10; pat[1] = 2'b11; pat[2] = 2'b01; pat[3] = 2'b00;
    end
    for (int p = 0; p < 4; p++) begin
      for (int r = 0; r <= int'(len); r++) begin
        @(negedge clk);
        if (!dir) c = start + 4'd1;
        else if (p == 3) c = start - 4'd1;
        else c = start;
        check_eq("phase_gates", {gate_one, gate_two}, pat[p]);
        check_eq("phase_busy", busy, 1'b1);
        check_eq("phase_ready", cmd_ready, 1'b0);
        check_eq("phase_done", done, 1'b0);
        check_eq("phase_count", model_count, c);
      end
    end
    @(negedge clk);
    check_eq("end_done", done, 1'b1);
    check_eq("end_ready", cmd_ready, 1'b1);
    check_eq("end_busy", busy, 1'b0);
    check_eq("end_gates", {gate_one, gate_two}, 2'b00);
  endtask

  initial begin
    int   acc_before;
    logic seen_done;
    reset     = 1'b1;
    cmd_valid = 1'b1;
    cmd_dir   = 1'b0;
    cmd_len   = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_gates", {gate_one, gate_two}, 2'b00);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_count", model_count, 4'd0);
    @(posedge clk); #1;
    reset     = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clk);
    check_eq("post_rst_ready", cmd_ready, 1'b1);
    check_eq("post_rst_busy", busy, 1'b0);

    do_cmd(1'b0, 4'd0);
    check_phases(1'b0, 4'd0, 4'd0);
    do_cmd(1'b1, 4'd2);
    check_phases(1'b1, 4'd2, 4'd1);
    do_cmd(1'b1, 4'd1);
    check_phases(1'b1, 4'd1, 4'd0);
    check_eq("wrap_down", model_count, 4'd15);
    do_cmd(1'b0, 4'd0);
    check_phases(1'b0, 4'd0, 4'd15);
    check_eq("wrap_up", model_count, 4'd0);

    // Held cmd_valid: second request must be taken in the done cycle.
    acc_before = n_acc;
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_dir   = 1'b0;
    cmd_len   = 4'd1;
    wait_done("b2b_done1_timeout");
    check_eq("b2b_ready_in_done", cmd_ready, 1'b1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    check_eq("b2b_p1_gates", {gate_one, gate_two}, 2'b10);
    check_eq("b2b_p1_busy", busy, 1'b1);
    wait_done("b2b_done2_timeout");
    check_eq("b2b_accepts", n_acc - acc_before, 32'd2);
    check_eq("b2b_count", model_count, 4'd2);

    // Reset during P2 of an enter aborts silently.
    do_cmd(1'b0, 4'd3);
    repeat (5) @(posedge clk);
    #1;
    check_eq("abort_in_p2", {gate_one, gate_two}, 2'b11);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_eq("abort_gates", {gate_one, gate_two}, 2'b00);
    check_eq("abort_busy", busy, 1'b0);
    check_eq("abort_count", model_count, 4'd0);
    check_eq("abort_ready", cmd_ready, 1'b1);
    seen_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done) seen_done = 1'b1;
      @(negedge clk);
    end
    check_eq("abort_no_done", seen_done, 1'b0);

    for (int i = 0; i < 50; i++) begin
      do_cmd(1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)));
      wait_done("rand_done_timeout");
    end
    repeat (3) @(negedge clk);
    check_eq("sb_empty", sb_q.size(), 32'd0);
    check_eq("all_done", n_done, n_acc - 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
